// File: rtl/div_sign_ctrl.sv
// div_sign_ctrl: signed/unsigned front-end and sign-restoring result stage for the radix-4 SRT divider
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset (shared with the divider core)
//   req_valid/ready  issue handshake; ready only while idle, a request with flush is not taken
//   req_op           00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1, rs2         dividend, divisor
//   flush            kills the in-flight request
//   resp_valid/ready result handshake; resp_data holds until taken
//   busy             controller not idle
//   core_start       one-cycle start pulse to the unsigned core
//   core_dividend    unsigned dividend magnitude, stable from start until core_valid
//   core_divisor     unsigned divisor magnitude, stable from start until core_valid
//   core_valid       core result strobe
//   core_q, core_rem unsigned quotient and remainder from the core
//
// Build option: define DIV_RESULT_CACHE_EN to keep the last normal result so a repeated
// DIV/REM (or DIVU/REMU) with identical operands completes without starting the core.
module div_sign_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic            core_start,
    output logic [XLEN-1:0] core_dividend,
    output logic [XLEN-1:0] core_divisor,
    input  logic            core_valid,
    input  logic [XLEN-1:0] core_q,
    input  logic [XLEN-1:0] core_rem
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      state;
    logic            op_rem, neg_q, neg_r;
    logic [XLEN-1:0] cq, cr, q_s, r_s, mag1, mag2, hit_data;
    logic            sgn, neg1, neg2, div0, ovf, accept, hit;

    assign sgn    = ~req_op[0];
    assign neg1   = sgn & rs1[XLEN-1];
    assign neg2   = sgn & rs2[XLEN-1];
    assign mag1   = neg1 ? ~rs1 + ONE : rs1;
    assign mag2   = neg2 ? ~rs2 + ONE : rs2;
    assign div0   = rs2 == '0;
    assign ovf    = sgn & (rs1 == MIN_NEG) & (&rs2);
    assign accept = req_valid & req_ready & ~flush;

    // Quotient sign follows the XOR of operand signs, remainder follows the dividend.
    assign q_s = neg_q ? ~cq + ONE : cq;
    assign r_s = neg_r ? ~cr + ONE : cr;

    assign req_ready  = state == S_IDLE;
    assign busy       = state != S_IDLE;
    assign resp_valid = state == S_DONE;
    assign core_start = state == S_START;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= S_IDLE;
            resp_data     <= '0;
            core_dividend <= '0;
            core_divisor  <= '0;
            op_rem        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            cq            <= '0;
            cr            <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_rem <= req_op[1];
                    if (div0) begin
                        resp_data <= req_op[1] ? rs1 : '1;
                        state     <= S_DONE;
                    end else if (ovf) begin
                        resp_data <= req_op[1] ? '0 : MIN_NEG;
                        state     <= S_DONE;
                    end else if (hit) begin
                        resp_data <= hit_data;
                        state     <= S_DONE;
                    end else begin
                        core_dividend <= mag1;
                        core_divisor  <= mag2;
                        neg_q         <= neg1 ^ neg2;
                        neg_r         <= neg1;
                        state         <= S_START;
                    end
                end
                // The core cannot abort, so a flushed operation must still swallow its strobe.
                S_START: state <= flush ? S_DRAIN : S_WAIT;
                S_WAIT: if (flush) begin
                    state <= core_valid ? S_IDLE : S_DRAIN;
                end else if (core_valid) begin
                    cq    <= core_q;
                    cr    <= core_rem;
                    state <= S_FIX;
                end
                S_FIX: if (flush) begin
                    state <= S_IDLE;
                end else begin
                    resp_data <= op_rem ? r_s : q_s;
                    state     <= S_DONE;
                end
                S_DONE:  if (flush || resp_ready) state <= S_IDLE;
                S_DRAIN: if (core_valid) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    logic            c_v, c_sgn, l_sgn;
    logic [XLEN-1:0] c_rs1, c_rs2, c_q, c_r, l_rs1, l_rs2;

    assign hit      = c_v & (c_sgn == sgn) & (c_rs1 == rs1) & (c_rs2 == rs2);
    assign hit_data = req_op[1] ? c_r : c_q;

    // Operands are latched on every accept and committed to the cache only when the
    // core path reaches FIX unflushed; special cases and flushes drop the entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            c_v <= 1'b0;
        end else if (flush || (accept && (div0 || ovf))) begin
            c_v <= 1'b0;
        end else if (accept) begin
            l_rs1 <= rs1;
            l_rs2 <= rs2;
            l_sgn <= sgn;
        end else if (state == S_FIX) begin
            c_v   <= 1'b1;
            c_rs1 <= l_rs1;
            c_rs2 <= l_rs2;
            c_sgn <= l_sgn;
            c_q   <= q_s;
            c_r   <= r_s;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
endmodule
